fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage and IF/ID pipeline register for the MIPS core. Holds the program counter, drives the instruction-memory address, and latches the fetched word and PC+4 into the IF/ID register. The opcode field feeds the main control decoder. Jump and taken-branch redirects are resolved from the instruction held in IF/ID; each redirect squashes the wrong-path fetch.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded at reset; must be word aligned
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hazard-unit hold; freezes PC and IF/ID
- jump  in  1  control-unit jump for the IF/ID instruction
- branch_taken  in  1  resolved beq/bne outcome for the IF/ID instruction
- imem_rdata  in  32  instruction word at imem_addr, combinational read
- imem_addr  out  32  current PC
- if_id_instr  out  32  registered instruction
- if_id_pc4  out  32  registered PC+4 of if_id_instr
- if_id_valid  out  1  1 = if_id_instr is a real fetched instruction, 0 = bubble
- opcode  out  6  if_id_instr[31:26], wired to control

## Operation
- Internal registers: pc (32), if_id_instr (32), if_id_pc4 (32), if_id_valid (1). No other state.
- imem_addr = pc, combinationally. pc_plus4 = pc + 4, modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
- jump_target = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00}.
- branch_target = if_id_pc4 + (sign-extended if_id_instr[15:0] << 2), 32-bit, wraps modulo 2^32.
- Redirects apply only when if_id_valid = 1. If if_id_valid = 0, jump and branch_taken are ignored.
- Per-edge update, evaluated in priority order:
  1. rst_n = 0 (asynchronous): pc <= RESET_PC; if_id_instr <= 0; if_id_pc4 <= 0; if_id_valid <= 0.
  2. stall = 1: all registers hold. Redirect inputs are ignored. The stalled IF/ID instruction presents the redirect again once the stall is released.
  3. valid jump: pc <= jump_target; IF/ID <= bubble (instr 0, pc4 0, valid 0).
  4. valid branch_taken (jump = 0): pc <= branch_target; IF/ID <= bubble.
  5. Otherwise: pc <= pc_plus4; if_id_instr <= imem_rdata; if_id_pc4 <= pc_plus4; if_id_valid <= 1.
- If jump and branch_taken are both asserted, jump wins.
- The bubble word 32'h0000_0000 decodes as opcode 000000 (a write to $0), so it is architecturally a NOP.
- opcode is zero whenever if_id_valid = 0.

## Timing
- Reset outputs: imem_addr = RESET_PC; if_id_instr = 0; if_id_pc4 = 0; if_id_valid = 0; opcode = 0. These values appear immediately on rst_n falling, independent of clk.
- Reset released mid-cycle: the first capture happens at the first rising edge with rst_n = 1.
- Fetch latency: a word on imem_rdata at edge N appears on if_id_instr after edge N.
- Redirect penalty: exactly one bubble cycle.
  - A jump in IF/ID at edge N makes imem_addr = target after N.
  - The target instruction is in IF/ID after edge N+1.
- Back-to-back redirects: a redirect cannot follow directly, because the slot after a redirect is always a bubble.
- Stall for K cycles: pc and IF/ID stay constant for K edges. Normal sequencing resumes at the first edge with stall = 0.
- Reset asserted during a stall or redirect: the reset values win immediately.

## Test plan
- Reset and sequential fetch:
  - Stimulus: rst_n low, then released; imem returns 32'h2008_0005 at 0 and 32'h2009_0003 at 4.
  - Required: after edge 1, if_id_instr = 32'h2008_0005, if_id_pc4 = 4, valid = 1, imem_addr = 4, opcode = 6'b001000.
- Jump:
  - Stimulus: IF/ID holds 32'h0800_0010 with pc4 = 8, and jump = 1.
  - Required: next imem_addr = 32'h0000_0040; IF/ID becomes bubble (valid = 0, opcode = 0); at the following edge IF/ID holds mem[0x40] with pc4 = 0x44.
- Taken branch, negative offset:
  - Stimulus: IF/ID holds 32'h1109_FFFE with pc4 = 0x20, and branch_taken = 1.
  - Required: pc = 0x18; one bubble follows.
- Stall:
  - Stimulus: stall = 1 for 3 edges while pc = 0x0C and jump = 1.
  - Required: pc, if_id_instr, if_id_pc4 and if_id_valid are unchanged for all 3 edges; the jump takes effect on the first edge after stall drops.
- Priority and ignore:
  - Stimulus 1: jump and branch_taken both asserted. Required: PC follows jump_target.
  - Stimulus 2: jump = 1 while if_id_valid = 0. Required: ignored; pc <= pc + 4.
- Wraparound and async reset:
  - Stimulus 1: pc = 32'hFFFF_FFFC with no redirect. Required: next pc = 0 and if_id_pc4 = 0.
  - Stimulus 2: rst_n dropped between edges. Required: imem_addr = RESET_PC and if_id_valid = 0 without a clock edge.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, instruction-memory address and the IF/ID
// pipeline register. Jumps and taken branches are resolved from the
// instruction already held in IF/ID. A redirect replaces the wrong-path
// fetch with a bubble, which costs exactly one cycle.
//
// There is no handshake on this block. The only flow control is stall,
// which freezes every register for as long as it is high.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jump,
    input  logic        branch_taken,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [5:0]  opcode
);

    // Architectural state
    logic [31:0] pc;

    // Next-state values and derived targets
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic        take_jump;
    logic        take_branch;
    logic [31:0] pc_next;
    logic [31:0] instr_next;
    logic [31:0] pc4_next;
    logic        valid_next;

    // Instruction memory is read combinationally at the current PC
    assign imem_addr = pc;

    // Sequential address. The 32-bit add wraps from 0xFFFF_FFFC to 0.
    assign pc_plus4 = pc + 32'd4;

    // J-type target: upper nibble of the delay-free PC+4, 26-bit word index
    assign jump_target = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};

    // Branch target: sign-extended word offset, relative to PC+4
    assign branch_offset = {{14{if_id_instr[15]}}, if_id_instr[15:0], 2'b00};
    assign branch_target = if_id_pc4 + branch_offset;

    // A bubble in IF/ID never redirects, whatever the control unit drives.
    // Jump has priority over a taken branch.
    assign take_jump   = if_id_valid & jump;
    assign take_branch = if_id_valid & branch_taken & ~jump;

    // Opcode is forced to zero for bubbles so control sees a clean NOP
    assign opcode = if_id_valid ? if_id_instr[31:26] : 6'd0;

    // Next-state selection: hold on stall, redirect with bubble, or fetch
    always_comb begin
        pc_next    = pc;
        instr_next = if_id_instr;
        pc4_next   = if_id_pc4;
        valid_next = if_id_valid;
        if (stall) begin
            // Hold everything. The held IF/ID instruction will present its
            // redirect again once the stall drops.
            pc_next    = pc;
            instr_next = if_id_instr;
            pc4_next   = if_id_pc4;
            valid_next = if_id_valid;
        end else if (take_jump) begin
            pc_next    = jump_target;
            instr_next = 32'd0;
            pc4_next   = 32'd0;
            valid_next = 1'b0;
        end else if (take_branch) begin
            pc_next    = branch_target;
            instr_next = 32'd0;
            pc4_next   = 32'd0;
            valid_next = 1'b0;
        end else begin
            pc_next    = pc_plus4;
            instr_next = imem_rdata;
            pc4_next   = pc_plus4;
            valid_next = 1'b1;
        end
    end

    // PC and IF/ID registers; reset takes effect without a clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            if_id_instr <= 32'd0;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
        end else begin
            pc          <= pc_next;
            if_id_instr <= instr_next;
            if_id_pc4   <= pc4_next;
            if_id_valid <= valid_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. A 64-word instruction memory model is
// indexed by imem_addr[7:2]. Inputs change 1 time unit after a rising edge
// and outputs are sampled at that same point.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [5:0]  opcode;

    logic [31:0] mem [64];

    int errors = 0;
    int checks = 0;

    // clock / reset block
    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[7:2]];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .jump         (jump),
        .branch_taken (branch_taken),
        .imem_rdata   (imem_rdata),
        .imem_addr    (imem_addr),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .opcode       (opcode)
    );

    // driver tasks
    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    endtask

    // Hold reset, let the caller load memory, release in mid-cycle
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        stall = 1'b0;
        jump = 1'b0;
        branch_taken = 1'b0;
        clear_mem();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, 32'h0); end
        checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=%h", if_id_instr, 32'h0); end
        checks++; if (if_id_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got=%h exp=%h", if_id_pc4, 32'h0); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
        checks++; if (opcode !== 6'h0) begin errors++; $display("FAIL reset_opcode got=%h exp=0", opcode); end
    endtask

    task automatic test_sequential();
        apply_reset();
        mem[0] = 32'h2008_0005;
        mem[1] = 32'h2009_0003;
        release_reset();
        step();
        checks++; if (if_id_instr !== 32'h2008_0005) begin errors++; $display("FAIL seq_instr0 got=%h exp=%h", if_id_instr, 32'h2008_0005); end
        checks++; if (if_id_pc4 !== 32'h4) begin errors++; $display("FAIL seq_pc4_0 got=%h exp=%h", if_id_pc4, 32'h4); end
        checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL seq_valid0 got=%b exp=1", if_id_valid); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL seq_addr0 got=%h exp=%h", imem_addr, 32'h4); end
        checks++; if (opcode !== 6'b001000) begin errors++; $display("FAIL seq_opcode0 got=%b exp=001000", opcode); end
        step();
        checks++; if (if_id_instr !== 32'h2009_0003) begin errors++; $display("FAIL seq_instr1 got=%h exp=%h", if_id_instr, 32'h2009_0003); end
        checks++; if (if_id_pc4 !== 32'h8) begin errors++; $display("FAIL seq_pc4_1 got=%h exp=%h", if_id_pc4, 32'h8); end
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL seq_addr1 got=%h exp=%h", imem_addr, 32'h8); end
    endtask

    task automatic test_jump();
        apply_reset();
        mem[0]  = 32'h2008_0005;
        mem[1]  = 32'h0800_0010;
        mem[2]  = 32'h2011_1111;
        mem[16] = 32'h2010_0001;
        release_reset();
        step();
        step();
        checks++; if (if_id_instr !== 32'h0800_0010 || if_id_pc4 !== 32'h8) begin errors++; $display("FAIL jmp_setup got=%h/%h exp=08000010/00000008", if_id_instr, if_id_pc4); end
        jump = 1'b1;
        step();
        jump = 1'b0;
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL jmp_addr got=%h exp=%h", imem_addr, 32'h40); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL jmp_bubble_valid got=%b exp=0", if_id_valid); end
        checks++; if (opcode !== 6'h0) begin errors++; $display("FAIL jmp_bubble_opcode got=%h exp=0", opcode); end
        checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL jmp_bubble_instr got=%h exp=0", if_id_instr); end
        step();
        checks++; if (if_id_instr !== 32'h2010_0001) begin errors++; $display("FAIL jmp_target_instr got=%h exp=%h", if_id_instr, 32'h2010_0001); end
        checks++; if (if_id_pc4 !== 32'h44) begin errors++; $display("FAIL jmp_target_pc4 got=%h exp=%h", if_id_pc4, 32'h44); end
        checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL jmp_target_valid got=%b exp=1", if_id_valid); end
    endtask

    task automatic test_branch_negative();
        apply_reset();
        for (int i = 0; i < 7; i++) mem[i] = 32'h2000_0000 + i;
        mem[7] = 32'h1109_FFFE;
        release_reset();
        for (int i = 0; i < 8; i++) step();
        checks++; if (if_id_instr !== 32'h1109_FFFE || if_id_pc4 !== 32'h20) begin errors++; $display("FAIL br_setup got=%h/%h exp=1109fffe/00000020", if_id_instr, if_id_pc4); end
        branch_taken = 1'b1;
        step();
        branch_taken = 1'b0;
        checks++; if (imem_addr !== 32'h18) begin errors++; $display("FAIL br_addr got=%h exp=%h", imem_addr, 32'h18); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL br_bubble got=%b exp=0", if_id_valid); end
        step();
        checks++; if (if_id_instr !== 32'h2000_0006 || if_id_pc4 !== 32'h1C) begin errors++; $display("FAIL br_target got=%h/%h exp=20000006/0000001c", if_id_instr, if_id_pc4); end
        checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL br_target_valid got=%b exp=1", if_id_valid); end
    endtask

    // Program shared by the stall and priority tests: jump at address 8
    // (pc4 = 0xC) to 0x80; as a branch its target would be 0x8C.
    task automatic load_jump_prog();
        mem[0]  = 32'h2008_0005;
        mem[1]  = 32'h2009_0003;
        mem[2]  = 32'h0800_0020;
        mem[3]  = 32'h2014_0004;
        mem[32] = 32'h2012_0007;
        mem[33] = 32'h2015_0008;
        mem[35] = 32'h2016_0009;
    endtask

    task automatic test_stall();
        apply_reset();
        load_jump_prog();
        release_reset();
        step();
        step();
        step();
        checks++; if (imem_addr !== 32'hC || if_id_instr !== 32'h0800_0020) begin errors++; $display("FAIL stall_setup got=%h/%h exp=0000000c/08000020", imem_addr, if_id_instr); end
        jump = 1'b1;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (imem_addr !== 32'hC || if_id_instr !== 32'h0800_0020 || if_id_pc4 !== 32'hC || if_id_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d got=%h/%h/%h/%b exp=0000000c/08000020/0000000c/1", k, imem_addr, if_id_instr, if_id_pc4, if_id_valid);
            end
        end
        stall = 1'b0;
        step();
        jump = 1'b0;
        checks++; if (imem_addr !== 32'h80 || if_id_valid !== 1'b0) begin errors++; $display("FAIL stall_release got=%h/%b exp=00000080/0", imem_addr, if_id_valid); end
        step();
        checks++; if (if_id_instr !== 32'h2012_0007 || if_id_pc4 !== 32'h84) begin errors++; $display("FAIL stall_target got=%h/%h exp=20120007/00000084", if_id_instr, if_id_pc4); end
    endtask

    task automatic test_priority_and_ignore();
        apply_reset();
        load_jump_prog();
        release_reset();
        step();
        step();
        step();
        jump = 1'b1;
        branch_taken = 1'b1;
        step();
        checks++; if (imem_addr !== 32'h80) begin errors++; $display("FAIL prio_jump_wins got=%h exp=%h", imem_addr, 32'h80); end
        // Redirect inputs stay high while IF/ID holds a bubble: ignored
        step();
        jump = 1'b0;
        branch_taken = 1'b0;
        checks++; if (imem_addr !== 32'h84) begin errors++; $display("FAIL ignore_addr got=%h exp=%h", imem_addr, 32'h84); end
        checks++; if (if_id_instr !== 32'h2012_0007 || if_id_valid !== 1'b1) begin errors++; $display("FAIL ignore_fetch got=%h/%b exp=20120007/1", if_id_instr, if_id_valid); end
    endtask

    task automatic test_wrap();
        apply_reset();
        mem[0]  = 32'h1000_FFFE;
        mem[63] = 32'h2013_0009;
        release_reset();
        step();
        branch_taken = 1'b1;
        step();
        branch_taken = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_branch got=%h exp=%h", imem_addr, 32'hFFFF_FFFC); end
        step();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=%h", imem_addr, 32'h0); end
        checks++; if (if_id_pc4 !== 32'h0 || if_id_instr !== 32'h2013_0009 || if_id_valid !== 1'b1) begin errors++; $display("FAIL wrap_ifid got=%h/%h/%b exp=00000000/20130009/1", if_id_pc4, if_id_instr, if_id_valid); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        load_jump_prog();
        release_reset();
        step();
        step();
        step();
        stall = 1'b1;
        jump = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL async_addr got=%h exp=%h", imem_addr, 32'h0); end
        checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || opcode !== 6'h0) begin errors++; $display("FAIL async_ifid got=%b/%h/%h exp=0/00000000/00", if_id_valid, if_id_instr, opcode); end
        step();
        checks++; if (imem_addr !== 32'h0 || if_id_valid !== 1'b0) begin errors++; $display("FAIL async_hold got=%h/%b exp=00000000/0", imem_addr, if_id_valid); end
        stall = 1'b0;
        jump = 1'b0;
    endtask

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // test sequence and final report
    initial begin
        clear_mem();
        test_reset();
        test_sequential();
        test_jump();
        test_branch_negative();
        test_stall();
        test_priority_and_ignore();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
